alu_result_reg: RTL and testbench
=================================

Name: alu_result_reg

Overview:
- Downstream stage of the 8-bit lab ALU. Captures the ALU result into an accumulator register on a pushbutton-style load request.
- Feeds the register's low nibble back as the ALU B operand.
- Keeps a small circular history of committed results, which the user steps through with a second request input to drive the HEX/LEDR displays.
- Both request inputs are synchronized and edge-detected, with a lockout window after every capture.

Parameters:
- WIDTH, 8, ALU result / register width.
- DEPTH, 4, history entries (power of two, ≥2).
- LOCKOUT, 16, idle cycles after each commit during which load edges are ignored.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_in  in  WIDTH  combinational ALU result (AluOut).
- load_req  in  1  asynchronous level request (button); each rising edge requests one capture.
- hist_req  in  1  asynchronous level request; each rising edge steps the history view.
- q  out  WIDTH  accumulator register.
- b_fb  out  4  q[3:0], the B-operand feedback to the ALU.
- hist_q  out  WIDTH  history entry currently selected.
- hist_idx  out  log2(DEPTH)  age of the selected entry (0 = newest).
- hist_count  out  log2(DEPTH)+1  number of valid history entries, saturating at DEPTH.
- zero  out  1  1 when q == 0.
- busy  out  1  1 whenever the FSM is not IDLE.

Behaviour:
- Reset: applies on a clk edge with reset=1. Clears:
  - q=0, hist_idx=0, hist_count=0, write pointer=0.
  - All synchronizer and edge flops=0.
  - Lockout counter=0, state=IDLE.
  - Resulting outputs: hist_q=0, zero=1, busy=0.
  - History RAM contents are don't-care because hist_count=0 masks them.
  - Reset overrides every other event, including mid-CAPTURE, mid-PUSH and mid-LOCKOUT.
- Synchronizers: each request passes through 2 flops (s1, s2) plus a delay flop s3.
  - rise = s2 & ~s3.
  - Let E0 be the first edge that samples load_req high. rise is asserted in the cycle after E1.
  - A level held high produces exactly one rise.
- FSM states are IDLE, CAPTURE, PUSH, LOCK.
  - IDLE: on load rise, go to CAPTURE (at E2). Otherwise stay in IDLE.
  - CAPTURE: q <= alu_in (takes effect at E3); go to PUSH.
  - PUSH: write q into hist[wr_ptr]; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
    - hist_count <= min(hist_count+1, DEPTH); hist_idx <= 0.
    - Lockout counter <= LOCKOUT-1; go to LOCK (all at E4).
  - LOCK: decrement the counter. Go to IDLE on the cycle the counter is 0.
    - LOCK lasts exactly LOCKOUT cycles, so the next capture is accepted no earlier than E4+LOCKOUT+1.
  - Load rises outside IDLE are discarded, not queued. The edge detector still tracks the input, so no rise is produced later for the same press.
- Latency: q updates at E3. The history entry and hist_count update at E4. busy is high from E2 through the last LOCK cycle.
- History read:
  - hist_q = hist[(wr_ptr-1-hist_idx) mod DEPTH] when hist_count>0; otherwise hist_q=0. This is combinational from the registers.
  - On hist rise: hist_idx <= (hist_idx+1) mod hist_count. If hist_count ≤1, hist_idx stays 0.
  - hist rises are accepted in every FSM state.
  - If a hist rise and a PUSH occur in the same cycle, PUSH wins and hist_idx=0.
- Wrap: once DEPTH commits have occurred, each new commit overwrites the oldest entry. hist_count stays at DEPTH.
- Arithmetic: the register performs no arithmetic. alu_in is stored unmodified and all WIDTH bits are kept.
- Combinational outputs: zero and b_fb derive from q only, never from alu_in.

Test Plan:
- Reset: hold reset 2 cycles with both requests low → q=0x00, zero=1, busy=0, hist_count=0, hist_q=0x00, b_fb=0x0.
- Single capture: alu_in=0x5A, load_req 0→1 held for 20 cycles → q=0x5A at E3, hist_count=1 and hist_q=0x5A at E4. busy high for exactly LOCKOUT+2 cycles. Only one capture occurs, b_fb=0xA, zero=0.
- Lockout: LOCKOUT=4, load pulses 3 cycles apart with alu_in changing 0x11→0x22 → second pulse ignored, q=0x11, hist_count=1. A pulse after busy falls with alu_in=0x33 → q=0x33, hist_count=2.
- Wrap: 5 spaced captures of 0x01,0x02,0x03,0x04,0x05, then 4 hist pulses → hist_count=4. hist_q sequence is 0x05 (idx0), then 0x04, 0x03, 0x02, then back to 0x05.
- Collision: issue a hist rise in the same cycle as PUSH of 0x77 while hist_idx=2 → hist_idx=0, hist_q=0x77.
- Reset mid-LOCK: capture 0xC3, assert reset during LOCK → all reset values restored. The next load of 0x0F is accepted immediately, giving q=0x0F and hist_count=1.

Source files
------------

// File: rtl/alu_result_reg.sv
// Accumulator register behind the lab ALU: captures alu_in on a debounced load press,
// keeps a circular history of committed values and lets a second button browse it.
module alu_result_reg #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LOCKOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           alu_in,
  input  logic                       load_req,
  input  logic                       hist_req,
  output logic [WIDTH-1:0]           q,
  output logic [3:0]                 b_fb,
  output logic [WIDTH-1:0]           hist_q,
  output logic [$clog2(DEPTH)-1:0]   hist_idx,
  output logic [$clog2(DEPTH):0]     hist_count,
  output logic                       zero,
  output logic                       busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, PUSH, LOCK} state_t;

  state_t           state, state_next;
  logic             load_s1, load_s2, load_s3;
  logic             hist_s1, hist_s2, hist_s3;
  logic             load_rise, hist_rise;
  logic [CW-1:0]    lock_cnt;
  logic [IW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] hist_mem [DEPTH];

  // Two-flop synchronizers plus a delay flop; the delay flop keeps tracking the
  // input even while the FSM ignores rises, so a held button never re-fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      {load_s1, load_s2, load_s3} <= 3'b000;
      {hist_s1, hist_s2, hist_s3} <= 3'b000;
    end else begin
      {load_s1, load_s2, load_s3} <= {load_req, load_s1, load_s2};
      {hist_s1, hist_s2, hist_s3} <= {hist_req, hist_s1, hist_s2};
    end
  end

  assign load_rise = load_s2 & ~load_s3;
  assign hist_rise = hist_s2 & ~hist_s3;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_rise) state_next = CAPTURE;
      CAPTURE: state_next = PUSH;
      PUSH:    state_next = LOCK;
      LOCK:    if (lock_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      wr_ptr     <= '0;
      hist_count <= '0;
      hist_idx   <= '0;
      lock_cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        CAPTURE: q <= alu_in;
        PUSH:    lock_cnt <= CW'(LOCKOUT - 1);
        LOCK:    if (lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
        default: ;
      endcase
      // A commit always snaps the view back to the newest entry, even over a browse press.
      if (state == PUSH) begin
        wr_ptr   <= wr_ptr + 1'b1;
        hist_idx <= '0;
        if (hist_count != (IW+1)'(DEPTH)) hist_count <= hist_count + 1'b1;
      end else if (hist_rise) begin
        if (hist_count <= (IW+1)'(1)) hist_idx <= '0;
        else if ({1'b0, hist_idx} + (IW+1)'(1) >= hist_count) hist_idx <= '0;
        else hist_idx <= hist_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == PUSH) hist_mem[wr_ptr] <= q;
  end

  assign rd_ptr = wr_ptr - IW'(1) - hist_idx;
  assign hist_q = (hist_count != '0) ? hist_mem[rd_ptr] : '0;
  assign b_fb   = q[3:0];
  assign zero   = (q == '0);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_result_reg.sv
// Directed bench for alu_result_reg: capture latency, lockout, history wrap/browse,
// browse/commit collision and reset during lockout, checked against a scoreboard.
module tb_alu_result_reg;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int LOCKOUT = 4;
  localparam int IW      = $clog2(DEPTH);

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] alu_in;
  logic             load_req;
  logic             hist_req;
  logic [WIDTH-1:0] q;
  logic [3:0]       b_fb;
  logic [WIDTH-1:0] hist_q;
  logic [IW-1:0]    hist_idx;
  logic [IW:0]      hist_count;
  logic             zero;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] committed[$];
  int               exp_count;
  int               exp_idx;

  alu_result_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOCKOUT(LOCKOUT)) dut (
    .clk(clk), .reset(reset), .alu_in(alu_in), .load_req(load_req), .hist_req(hist_req),
    .q(q), .b_fb(b_fb), .hist_q(hist_q), .hist_idx(hist_idx), .hist_count(hist_count),
    .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_commit(input logic [WIDTH-1:0] val);
    committed.push_back(val);
    if (exp_count < DEPTH) exp_count++;
    exp_idx = 0;
  endfunction

  function automatic logic [WIDTH-1:0] model_view();
    return committed[committed.size() - 1 - exp_idx];
  endfunction

  task automatic apply_reset(input int cycles);
    reset = 1'b1; load_req = 1'b0; hist_req = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
    exp_q.delete(); committed.delete();
    exp_count = 0; exp_idx = 0;
    check("rst_q", q, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_hist_count", hist_count, 0);
    check("rst_hist_q", hist_q, 0);
    check("rst_b_fb", b_fb, 0);
    check("rst_hist_idx", hist_idx, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("idle_bound", n < 100, 1);
  endtask

  // Press load for 'hold' cycles and follow one capture through E2..E4 and the lockout.
  task automatic commit(input logic [WIDTH-1:0] val, input int hold);
    int t = 0;
    int bc = 0;
    alu_in = val; load_req = 1'b1;
    exp_q.push_back(val);
    for (int k = 1; k <= 5; k++) begin
      if (k > hold) load_req = 1'b0;
      tick(); t++;
      if (busy) bc++;
      case (k)
        2: check("busy_before_e2", busy, 0);
        3: check("busy_at_e2", busy, 1);
        4: begin
          check("q_at_e3", q, exp_q.pop_front());
          check("b_fb_at_e3", b_fb, val[3:0]);
          check("zero_at_e3", zero, val == '0);
        end
        5: begin
          model_commit(val);
          check("hist_count_e4", hist_count, exp_count);
          check("hist_q_e4", hist_q, val);
          check("hist_idx_e4", hist_idx, 0);
        end
        default: ;
      endcase
    end
    while ((busy || t < hold) && t < 200) begin
      if (t >= hold) load_req = 1'b0;
      tick(); t++;
      if (busy) bc++;
    end
    check("busy_bound", t < 200, 1);
    check("busy_len", bc, LOCKOUT + 2);
    load_req = 1'b0;
    repeat (3) tick();
    check("q_after_commit", q, val);
    check("busy_after_commit", busy, 0);
  endtask

  task automatic hist_step();
    if (exp_count > 1) exp_idx = (exp_idx + 1) % exp_count;
    else exp_idx = 0;
    exp_q.push_back(model_view());
    hist_req = 1'b1; tick();
    hist_req = 1'b0; tick(); tick();
    check("hist_idx_step", hist_idx, exp_idx);
    check("hist_q_step", hist_q, exp_q.pop_front());
    tick();
  endtask

  initial begin
    reset = 1'b1; load_req = 1'b0; hist_req = 1'b0; alu_in = '0;
    exp_count = 0; exp_idx = 0;

    // Reset and a single long press
    apply_reset(2);
    commit(8'h5A, 20);
    check("single_count", hist_count, 1);

    // Lockout: second press lands in LOCK and is dropped
    apply_reset(2);
    alu_in = 8'h11; load_req = 1'b1; exp_q.push_back(8'h11);
    tick(); load_req = 1'b0;
    tick(); tick();
    check("lock_busy_e2", busy, 1);
    tick();
    check("lock_q_e3", q, exp_q.pop_front());
    model_commit(8'h11);
    alu_in = 8'h22; load_req = 1'b1;
    tick(); load_req = 1'b0;
    wait_idle();
    repeat (4) tick();
    check("lock_q_kept", q, 8'h11);
    check("lock_count", hist_count, exp_count);
    check("lock_no_retrigger", busy, 0);
    commit(8'h33, 1);
    check("lock_count2", hist_count, 2);

    // Wrap: five commits into four slots, then browse all the way round
    apply_reset(2);
    for (int v = 1; v <= 5; v++) commit(WIDTH'(v), 1);
    check("wrap_count", hist_count, DEPTH);
    check("wrap_newest", hist_q, model_view());
    for (int i = 0; i < 4; i++) hist_step();

    // Collision: browse rise sampled on the PUSH edge while viewing idx 2
    hist_step(); hist_step();
    check("coll_idx_pre", hist_idx, 2);
    alu_in = 8'h77; load_req = 1'b1; exp_q.push_back(8'h77);
    tick(); load_req = 1'b0;
    tick(); hist_req = 1'b1;
    tick(); hist_req = 1'b0;
    tick();
    check("coll_q_e3", q, exp_q.pop_front());
    tick();
    model_commit(8'h77);
    check("coll_idx", hist_idx, exp_idx);
    check("coll_hist_q", hist_q, 8'h77);
    check("coll_count", hist_count, exp_count);
    wait_idle();
    check("coll_idx_after", hist_idx, 0);

    // Reset while in LOCK, then an immediate fresh capture
    alu_in = 8'hC3; load_req = 1'b1;
    repeat (6) tick();
    check("midlock_busy", busy, 1);
    check("midlock_q", q, 8'hC3);
    apply_reset(1);
    commit(8'h0F, 1);
    check("post_reset_count", hist_count, 1);
    check("post_reset_hist_q", hist_q, 8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
